// File: rtl/addsub_simd_pipe.sv
// N-lane signed add/subtract pipeline with wrap or saturate arithmetic,
// clock-enable stall, valid tracking and per-lane overflow (live and sticky).
module addsub_simd_pipe #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int LATENCY = 2,
  parameter int SAT     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic                     op,
  input  logic [WIDTH*LANES-1:0]   a,
  input  logic [WIDTH*LANES-1:0]   b,
  output logic                     out_valid,
  output logic [WIDTH*LANES-1:0]   y,
  output logic [LANES-1:0]         ovf,
  output logic [LANES-1:0]         ovf_sticky
);

  localparam int VW = WIDTH * LANES;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH:0] lane_sum(input logic sub,
                                                     input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] z);
    logic signed [WIDTH:0] xe;
    logic signed [WIDTH:0] ze;
    xe = {x[WIDTH-1], x};
    ze = {z[WIDTH-1], z};
    return sub ? (xe - ze) : (xe + ze);
  endfunction

  function automatic logic lane_ovf(input logic signed [WIDTH:0] r);
    return r[WIDTH] != r[WIDTH-1];
  endfunction

  function automatic logic signed [WIDTH-1:0] lane_round(input logic signed [WIDTH:0] r);
    if (SAT != 0 && lane_ovf(r))
      return r[WIDTH] ? SMIN : SMAX;
    return r[WIDTH-1:0];
  endfunction

  logic          src_vld;
  logic          src_op;
  logic [VW-1:0] src_a;
  logic [VW-1:0] src_b;

  // Operand delay stages: LATENCY-1 registers ahead of the output register.
  if (LATENCY > 1) begin : g_stages
    localparam int DEPTH = LATENCY - 1;
    logic [VW-1:0] a_p   [DEPTH];
    logic [VW-1:0] b_p   [DEPTH];
    logic          op_p  [DEPTH];
    logic          vld_p [DEPTH];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) vld_p[i] <= 1'b0;
      end else if (en) begin
        vld_p[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clock) begin
      if (en) begin
        if (in_valid) begin
          a_p[0]  <= a;
          b_p[0]  <= b;
          op_p[0] <= op;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (vld_p[i-1]) begin
            a_p[i]  <= a_p[i-1];
            b_p[i]  <= b_p[i-1];
            op_p[i] <= op_p[i-1];
          end
        end
      end
    end

    assign src_vld = vld_p[DEPTH-1];
    assign src_op  = op_p[DEPTH-1];
    assign src_a   = a_p[DEPTH-1];
    assign src_b   = b_p[DEPTH-1];
  end else begin : g_direct
    assign src_vld = in_valid;
    assign src_op  = op;
    assign src_a   = a;
    assign src_b   = b;
  end

  logic [VW-1:0]           y_nxt;
  logic [LANES-1:0]        ovf_nxt;
  logic [LANES-1:0]        set_evt;
  logic signed [WIDTH:0]   lane_r;

  // Lane arithmetic feeding the output register.
  always_comb begin
    y_nxt   = '0;
    ovf_nxt = '0;
    lane_r  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_r                     = lane_sum(src_op, src_a[l*WIDTH +: WIDTH], src_b[l*WIDTH +: WIDTH]);
      y_nxt[l*WIDTH +: WIDTH]    = lane_round(lane_r);
      ovf_nxt[l]                 = lane_ovf(lane_r);
    end
    set_evt = (en && src_vld) ? ovf_nxt : '0;
  end

  // Output stage: y/ovf hold across bubbles; sticky set beats clr.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      y          <= '0;
      ovf        <= '0;
      ovf_sticky <= '0;
    end else begin
      if (en) begin
        out_valid <= src_vld;
        if (src_vld) begin
          y   <= y_nxt;
          ovf <= ovf_nxt;
        end
      end
      ovf_sticky <= (clr ? '0 : ovf_sticky) | set_evt;
    end
  end

endmodule

// File: tb/tb_addsub_simd_pipe.sv
// Bench for addsub_simd_pipe: three configurations driven in lockstep and
// compared every cycle against a token-history reference model.
module tb_addsub_simd_pipe;

  logic        clock;
  logic        reset;
  logic        en;
  logic        clr;
  logic        in_valid;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;

  logic        ov1, ov2, ov3;
  logic [7:0]  y1;
  logic [31:0] y2, y3;
  logic [0:0]  f1, s1;
  logic [3:0]  f2, f3, s2, s3;

  int checks = 0;
  int errors = 0;

  addsub_simd_pipe #(.WIDTH(8), .LANES(1), .LATENCY(1), .SAT(0)) dut1 (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid), .op(op),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov1), .y(y1), .ovf(f1), .ovf_sticky(s1));

  addsub_simd_pipe #(.WIDTH(8), .LANES(4), .LATENCY(2), .SAT(0)) dut2 (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid), .op(op),
    .a(a), .b(b), .out_valid(ov2), .y(y2), .ovf(f2), .ovf_sticky(s2));

  addsub_simd_pipe #(.WIDTH(8), .LANES(4), .LATENCY(3), .SAT(1)) dut3 (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid), .op(op),
    .a(a), .b(b), .out_valid(ov3), .y(y3), .ovf(f3), .ovf_sticky(s3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          vld;
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
  } tok_t;

  tok_t        hist[$];
  int          lats[3] = '{1, 2, 3};
  bit          sats[3] = '{0, 0, 1};
  int          nls[3]  = '{1, 4, 4};
  bit          m_v[3];
  logic [31:0] m_y[3];
  logic [3:0]  m_f[3];
  logic [3:0]  m_s[3];

  function automatic void calc(input tok_t t, input bit sat, input int nl,
                               output logic [31:0] yv, output logic [3:0] fv);
    int av, bv, r;
    yv = '0;
    fv = '0;
    for (int l = 0; l < nl; l++) begin
      av = $signed(t.a[8*l +: 8]);
      bv = $signed(t.b[8*l +: 8]);
      r  = t.op ? av - bv : av + bv;
      if (r > 127 || r < -128) fv[l] = 1'b1;
      if (fv[l] && sat) r = (r > 127) ? 127 : -128;
      yv[8*l +: 8] = r[7:0];
    end
  endfunction

  task automatic model_edge();
    tok_t       nt, t;
    logic [3:0] set;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < 3; k++) begin
        m_v[k] = 0; m_y[k] = '0; m_f[k] = '0; m_s[k] = '0;
      end
    end else begin
      if (en) begin
        nt.vld = in_valid; nt.op = op; nt.a = a; nt.b = b;
        hist.push_back(nt);
        if (hist.size() > 4) void'(hist.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        set = '0;
        if (en) begin
          t.vld = 0; t.op = 0; t.a = '0; t.b = '0;
          if (hist.size() >= lats[k]) t = hist[hist.size() - lats[k]];
          m_v[k] = t.vld;
          if (t.vld) begin
            calc(t, sats[k], nls[k], m_y[k], m_f[k]);
            set = m_f[k];
          end
        end
        m_s[k] = (clr ? 4'b0 : m_s[k]) | set;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("v1", 32'(ov1), 32'(m_v[0]));
    chk("y1", 32'(y1),  m_y[0]);
    chk("f1", 32'(f1),  32'(m_f[0]));
    chk("s1", 32'(s1),  32'(m_s[0]));
    chk("v2", 32'(ov2), 32'(m_v[1]));
    chk("y2", y2,       m_y[1]);
    chk("f2", 32'(f2),  32'(m_f[1]));
    chk("s2", 32'(s2),  32'(m_s[1]));
    chk("v3", 32'(ov3), 32'(m_v[2]));
    chk("y3", y3,       m_y[2]);
    chk("f3", 32'(f3),  32'(m_f[2]));
    chk("s3", 32'(s3),  32'(m_s[2]));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1; en = 1; clr = 0; in_valid = 0; op = 0; a = '0; b = '0;
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_y[k] = '0; m_f[k] = '0; m_s[k] = '0;
    end
    #1;
    step(); step();
    chk("rst_v2", 32'(ov2), 32'd0);
    chk("rst_y3", y3, 32'd0);
    reset = 0;

    // 9 - 3 on the single-lane, latency-1 instance
    a = 32'h0000_0009; b = 32'h0000_0003; op = 1; in_valid = 1;
    step();
    chk("tp1_y", 32'(y1), 32'd6);
    chk("tp1_v", 32'(ov1), 32'd1);
    chk("tp1_f", 32'(f1), 32'd0);
    in_valid = 0;

    // four-lane add with lane 3 overflowing
    a = 32'h7F80_0500; b = 32'h0101_FD00; op = 0; in_valid = 1;
    step();
    in_valid = 0;
    step();
    chk("tp2_wrap_y", y2, 32'h8081_0200);
    chk("tp2_wrap_f", 32'(f2), 32'h8);
    step();
    chk("tp2_sat_y", y3, 32'h7F81_0200);
    chk("tp2_sat_f", 32'(f3), 32'h8);

    // -128 - 1 on lane 0
    a = 32'h0000_0080; b = 32'h0000_0001; op = 1; in_valid = 1;
    step();
    chk("tp3_wrap_y", 32'(y1), 32'h7F);
    chk("tp3_wrap_f", 32'(f1), 32'd1);
    in_valid = 0;
    step(); step();
    chk("tp3_sat_y", y3, 32'h0000_0080);
    chk("tp3_sat_f", 32'(f3), 32'h1);

    // three back-to-back tokens with a two-cycle stall mid-stream
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; op = 1'($urandom); in_valid = 1;
      step();
    end
    in_valid = 0; en = 0;
    step(); step();
    en = 1;
    for (int i = 0; i < 4; i++) step();

    // two tokens in flight, then a one-cycle reset
    a = $urandom; b = $urandom; in_valid = 1;
    step();
    a = $urandom; b = $urandom;
    step();
    in_valid = 0; reset = 1;
    step();
    chk("rst_mid_v2", 32'(ov2), 32'd0);
    chk("rst_mid_y2", y2, 32'd0);
    reset = 0;
    for (int i = 0; i < 4; i++) step();

    // sticky set, then clr on the same edge as a new overflow result
    clr = 1;
    step();
    clr = 0;
    a = 32'h007F_0000; b = 32'h0001_0000; op = 0; in_valid = 1;
    step();
    in_valid = 0;
    step();
    chk("stk_lane2", 32'(s2), 32'h4);
    a = 32'h0000_0080; b = 32'h0000_0001; op = 1; in_valid = 1;
    step();
    in_valid = 0; clr = 1;
    step();
    chk("stk_clr_set", 32'(s2), 32'h1);
    clr = 0;
    for (int i = 0; i < 3; i++) step();

    // randomized traffic with stalls, clears and occasional resets
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(99, 0) < 80);
      in_valid = 1'($urandom);
      op       = 1'($urandom);
      a        = $urandom;
      b        = $urandom;
      clr      = ($urandom_range(99, 0) < 5);
      reset    = ($urandom_range(99, 0) < 2);
      step();
    end
    reset = 0; clr = 0; en = 1; in_valid = 0;
    for (int i = 0; i < 4; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
